clk_gate_ctrl: RTL



---
 rtl/clk_gate_pkg.sv | 15 +
 rtl/clk_gate_if.sv | 39 +++
 rtl/clk_gate_sat_cnt.sv | 35 +++
 rtl/clk_gate_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and default widths for the idle-detect clock-gating controller.
package clk_gate_pkg;

  localparam int IdleCntWDef  = 8;
  localparam int WakeDelayDef = 2;
  localparam int GateCntWDef  = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    COUNT = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } clk_gate_state_e;

endpackage

// File: rtl/clk_gate_if.sv
// Control/status bundle between the power-management side and clk_gate_ctrl.
//
// Request/acknowledge semantics: wake_req_i, force_on_i and !auto_gate_en_i
// are level requests sampled on every rising edge. They need no handshake.
// A request seen in GATED starts a wake sequence that always runs to
// completion. wake_ack_o is a single-cycle pulse in the last WAKE cycle, and
// the controller is back in RUN on the next edge. clk_en_o and gated_o are
// registered and change only on rising edges.
interface clk_gate_if
  import clk_gate_pkg::*;
#(
  parameter int IdleCntW = IdleCntWDef,
  parameter int GateCntW = GateCntWDef
) ();

  logic                auto_gate_en_i;
  logic                force_on_i;
  logic                busy_i;
  logic                wake_req_i;
  logic [IdleCntW-1:0] idle_thresh_i;
  logic                clk_en_o;
  logic                gated_o;
  logic                wake_ack_o;
  logic [GateCntW-1:0] gate_cnt_o;
  clk_gate_state_e     dbg_state_o;

  // Driver side: power-management logic or a testbench.
  modport master (
    output auto_gate_en_i, force_on_i, busy_i, wake_req_i, idle_thresh_i,
    input  clk_en_o, gated_o, wake_ack_o, gate_cnt_o, dbg_state_o
  );

  // Controller side.
  modport slave (
    input  auto_gate_en_i, force_on_i, busy_i, wake_req_i, idle_thresh_i,
    output clk_en_o, gated_o, wake_ack_o, gate_cnt_o, dbg_state_o
  );

endinterface

// File: rtl/clk_gate_sat_cnt.sv
// Generic saturating up-counter with synchronous clear; clear beats increment.
module clk_gate_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next value: clear, otherwise increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller. It produces a registered enable for a
// downstream latch-based clock gate. It gates after a programmable run of idle
// cycles and re-enables on wake, force, or when software disables auto-gating.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IdleCntW  = IdleCntWDef,
  parameter int WakeDelay = WakeDelayDef,
  parameter int GateCntW  = GateCntWDef
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  clk_gate_if.slave  bus
);

  localparam int WakeCntW = (WakeDelay < 1) ? 1 : $clog2(WakeDelay + 1);
  localparam logic [WakeCntW-1:0] WakeLast = WakeCntW'(WakeDelay);

  clk_gate_state_e     state_q, state_d;
  logic [WakeCntW-1:0] wake_cnt_q, wake_cnt_d;
  logic [IdleCntW-1:0] cnt_q;
  logic                clk_en_q, gated_q, wake_ack_q, wake_ack_d;
  logic                wake_src, hold;
  logic                count_stay, gate_entry;

  // busy_i is left out of wake_src because a gated domain cannot report activity.
  assign wake_src = bus.wake_req_i | bus.force_on_i | ~bus.auto_gate_en_i;
  assign hold     = bus.busy_i | wake_src;

  // Next-state and wake settle counter. Hold beats a threshold match in COUNT.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = '0;
    case (state_q)
      RUN: begin
        if (!hold) state_d = COUNT;
      end
      COUNT: begin
        if (hold) begin
          state_d = RUN;
        end else if (cnt_q >= bus.idle_thresh_i) begin
          state_d = GATED;
        end
      end
      GATED: begin
        if (wake_src) state_d = WAKE;
      end
      WAKE: begin
        if (wake_cnt_q == WakeLast) begin
          state_d = RUN;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // The ack is high during the last WAKE cycle, so it is registered one edge early.
  assign wake_ack_d = (state_d == WAKE) && (wake_cnt_d == WakeLast);

  assign count_stay = (state_q == COUNT) && (state_d == COUNT);
  assign gate_entry = (state_q == COUNT) && (state_d == GATED);

  // Idle-cycle counter. It restarts from zero every time COUNT is entered.
  clk_gate_sat_cnt #(.W(IdleCntW)) u_idle_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (~count_stay),
    .inc_i  (count_stay),
    .cnt_o  (cnt_q)
  );

  // Count of GATED entries, saturating at all-ones.
  clk_gate_sat_cnt #(.W(GateCntW)) u_gate_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (1'b0),
    .inc_i  (gate_entry),
    .cnt_o  (bus.gate_cnt_o)
  );

  // State and registered outputs. Reset leaves the clock enabled for the consumer's own reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      wake_cnt_q <= '0;
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= (state_d != GATED);
      gated_q    <= (state_d == GATED);
      wake_ack_q <= wake_ack_d;
    end
  end

  assign bus.clk_en_o    = clk_en_q;
  assign bus.gated_o     = gated_q;
  assign bus.wake_ack_o  = wake_ack_q;
  assign bus.dbg_state_o = state_q;

endmodule
